// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: start/done handshake, ROM bus and decoded instruction fields of instr_sequencer.
interface instr_sequencer_if #(parameter int ADDR_W = 8);
   logic              start, stop;
   logic [ADDR_W-1:0] start_addr, rom_addr;
   logic [23:0]       rom_data;
   logic [3:0]        op, wa, ra1, ra2;
   logic signed [7:0] ext_data;
   logic              cu_regwrite, rf_regwrite, busy, done, halted;
   logic [ADDR_W:0]   instr_count;
   modport master (output start, stop, start_addr, rom_data, cu_regwrite,
                   input rom_addr, op, wa, ra1, ra2, ext_data, rf_regwrite, busy, done, halted, instr_count);
   modport slave  (input start, stop, start_addr, rom_data, cu_regwrite,
                   output rom_addr, op, wa, ra1, ra2, ext_data, rf_regwrite, busy, done, halted, instr_count);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/DECODE/EXEC controller over a combinational instruction ROM.
// Define SEQ_BRANCH_EN to make OP_JUMP load pc from the immediate field.
module instr_sequencer #(
   parameter int              ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF,
   parameter logic [3:0]      OP_HALT   = 4'hF,
   parameter logic [3:0]      OP_JUMP   = 4'hE
) (
   input logic                clk,
   input logic                rst,
   instr_sequencer_if.slave   bus
);
`ifdef SEQ_BRANCH_EN
   localparam bit BRANCH = 1'b1;
`else
   localparam bit BRANCH = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, DONE} state_t;
   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [23:0]       ir, ir_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic              halted_n, is_halt, is_jump;
   assign is_halt         = ir[23:20] == OP_HALT;
   assign is_jump         = BRANCH && ir[23:20] == OP_JUMP;
   assign bus.rom_addr    = pc;
   assign bus.op          = ir[23:20];
   assign bus.wa          = ir[19:16];
   assign bus.ra1         = ir[15:12];
   assign bus.ra2         = ir[11:8];
   assign bus.ext_data    = ir[7:0];
   assign bus.instr_count = cnt;
   assign bus.busy        = state inside {FETCH, DECODE, EXEC};
   assign bus.done        = state == DONE;
   // Combinational on state so an asynchronous reset in EXEC drops the write at once.
   assign bus.rf_regwrite = state == EXEC && bus.cu_regwrite && !is_halt && !is_jump;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         ir         <= '0;
         cnt        <= '0;
         bus.halted <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         ir         <= ir_n;
         cnt        <= cnt_n;
         bus.halted <= halted_n;
      end
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ir_n     = ir;
      cnt_n    = cnt;
      halted_n = bus.halted;
      case (state)
         IDLE, DONE: if (bus.start) begin
            state_n  = FETCH;
            pc_n     = bus.start_addr;
            ir_n     = '0;
            cnt_n    = '0;
            halted_n = 1'b0;
         end
         FETCH: begin
            ir_n    = bus.rom_data;
            state_n = bus.stop ? DONE : DECODE;
         end
         DECODE: state_n = bus.stop ? DONE : EXEC;
         EXEC: begin
            cnt_n = cnt + 1'b1;
            if (is_halt) begin
               state_n  = DONE;
               halted_n = 1'b1;
            end else if (is_jump) begin
               pc_n    = ADDR_W'(ir[7:0]);
               state_n = bus.stop ? DONE : FETCH;
            end else if (pc == LAST_ADDR || bus.stop)
               state_n = DONE;
            else begin
               pc_n    = pc + 1'b1;
               state_n = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed runs against a small load/add datapath model with LAST_ADDR=3.
module tb_instr_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   int passed = 0, total = 0, writes = 0, cyc = 0, w0 = 0;
   logic [23:0] rom [256];
   logic [7:0]  rf [16];
   instr_sequencer_if #(.ADDR_W(8)) bus ();
   instr_sequencer #(.ADDR_W(8), .LAST_ADDR(8'h03)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   assign bus.rom_data    = rom[bus.rom_addr];
   assign bus.cu_regwrite = bus.op inside {4'h1, 4'h2, 4'hE};
   always @(posedge clk)
      if (bus.rf_regwrite) begin
         writes <= writes + 1;
         rf[bus.wa] <= bus.op == 4'h2 ? rf[bus.ra1] + rf[bus.ra2] : bus.ext_data;
      end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else passed++;
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clear;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      for (int i = 0; i < 16; i++) rf[i] = '0;
   endtask
   task automatic kick(input logic [7:0] sa);
      bus.start = 1'b1;
      bus.start_addr = sa;
      tick;
      bus.start = 1'b0;
   endtask
   task automatic run(input logic [7:0] sa);
      w0 = writes;
      kick(sa);
      cyc = 0;
      while (!bus.done && cyc < 100) begin
         tick;
         cyc++;
      end
      check("run_timeout", cyc < 100, 1);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.start_addr = '0;
      clear;
      tick;
      tick;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_count", bus.instr_count, 0);
      check("rst_regwrite", bus.rf_regwrite, 0);
      check("rst_rom_addr", bus.rom_addr, 0);
      check("rst_fields", {bus.op, bus.wa, bus.ra1, bus.ra2, bus.ext_data}, 0);
      rst = 1'b0;
      tick;
      rom[0] = {4'h1, 4'h1, 8'h00, 8'd5};
      rom[1] = {4'h1, 4'h2, 8'h00, 8'd3};
      rom[2] = {4'h2, 4'h3, 4'h1, 4'h2, 8'h00};
      rom[3] = {4'hF, 20'h0};
      run(8'h00);
      check("halt_cycles", cyc, 12);
      check("halt_writes", writes - w0, 3);
      check("halt_r3", rf[3], 8);
      check("halt_halted", bus.halted, 1);
      check("halt_count", bus.instr_count, 4);
      check("halt_busy", bus.busy, 0);
      clear;
      rom[0] = {4'h1, 4'h6, 8'h00, 8'd9};
      kick(8'h00);
      tick;
      tick;
      check("exec_regwrite", bus.rf_regwrite, 1);
      w0 = writes;
      rst = 1'b1;
      #1;
      check("arst_regwrite", bus.rf_regwrite, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_count", bus.instr_count, 0);
      check("arst_op", bus.op, 0);
      tick;
      check("arst_no_write", writes - w0, 0);
      check("arst_r6", rf[6], 0);
      rst = 1'b0;
      tick;
      clear;
      rom[3] = {4'h1, 4'h4, 8'h00, 8'd7};
      run(8'h03);
      check("last_cycles", cyc, 3);
      check("last_writes", writes - w0, 1);
      check("last_r4", rf[4], 7);
      check("last_halted", bus.halted, 0);
      check("last_count", bus.instr_count, 1);
      check("last_pc", bus.rom_addr, 3);
      clear;
      rom[0] = {4'h1, 4'h1, 8'h00, 8'd5};
      rom[1] = {4'h1, 4'h2, 8'h00, 8'd3};
      rom[2] = {4'hF, 20'h0};
      w0 = writes;
      kick(8'h00);
      tick;
      tick;
      tick;
      bus.start = 1'b1;
      bus.start_addr = 8'h02;
      tick;
      bus.start = 1'b0;
      check("stop_start_ignored", bus.rom_addr, 1);
      check("stop_busy", bus.busy, 1);
      bus.stop = 1'b1;
      tick;
      bus.stop = 1'b0;
      check("stop_done", bus.done, 1);
      check("stop_writes", writes - w0, 1);
      check("stop_count", bus.instr_count, 1);
      check("stop_r2", rf[2], 0);
      clear;
      rom[0] = {4'hE, 4'h5, 8'h00, 8'h02};
      rom[2] = {4'hF, 20'h0};
      w0 = writes;
      kick(8'h00);
      tick;
      tick;
      tick;
`ifdef SEQ_BRANCH_EN
      check("jump_pc", bus.rom_addr, 2);
`else
      check("jump_pc", bus.rom_addr, 1);
`endif
      cyc = 0;
      while (!bus.done && cyc < 100) begin
         tick;
         cyc++;
      end
      check("jump_timeout", cyc < 100, 1);
      check("jump_halted", bus.halted, 1);
`ifdef SEQ_BRANCH_EN
      check("jump_writes", writes - w0, 0);
      check("jump_count", bus.instr_count, 2);
`else
      check("jump_writes", writes - w0, 1);
      check("jump_count", bus.instr_count, 3);
      check("jump_r5", rf[5], 2);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute controller that steps through the 24-bit instruction ROM and drives the control unit and the register-file/ALU datapath. It replaces bench-side address stepping with a program counter and a start/done handshake, and it gates register writes to one clean cycle per instruction. It recognises a HALT opcode and, when configured, a JUMP opcode. All other opcodes pass through to `cu`.

## Interface
Parameters:
- `ADDR_W`, 8: ROM address width.
- `LAST_ADDR`, 8'hFF: the sequence ends after the instruction at this address executes.
- `OP_HALT`, 4'hF: opcode that ends the sequence.
- `OP_JUMP`, 4'hE: jump opcode, used only when `SEQ_BRANCH_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock; the single clock of the block.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sequence at `start_addr`; sampled only in IDLE or DONE.
- `stop`  in  1  abort request.
- `start_addr`  in  ADDR_W  first instruction address.
- `rom_addr`  out  ADDR_W  address to `rom`; ROM read is combinational.
- `rom_data`  in  24  instruction word from `rom`.
- `op`  out  4  ir[23:20], to `cu`.
- `wa`  out  4  ir[19:16], write address to the register file.
- `ra1`  out  4  ir[15:12], read address 1.
- `ra2`  out  4  ir[11:8], read address 2.
- `ext_data`  out  8 signed  ir[7:0], immediate to the datapath.
- `cu_regwrite`  in  1  regwrite decoded by `cu` from `op`.
- `rf_regwrite`  out  1  gated write enable to the register file.
- `busy`  out  1  high in FETCH, DECODE and EXEC.
- `done`  out  1  high in DONE.
- `halted`  out  1  high in DONE when the sequence ended on HALT.
- `instr_count`  out  ADDR_W+1  number of instructions executed in the current or last sequence.

## Operation
States are IDLE, FETCH, DECODE, EXEC and DONE.
- **IDLE / DONE:** `start`=1 loads pc←`start_addr`, ir←0, `instr_count`←0 and `halted`←0, then moves to FETCH.
- **FETCH:** `rom_addr`=pc. At the clock edge, ir←`rom_data`. Next state is DECODE.
- **DECODE:** fields are driven from ir so that `cu` and the register-file read ports settle. `rf_regwrite`=0. Next state is EXEC.
- **EXEC:**
  - `rf_regwrite` = `cu_regwrite`, except that it is forced to 0 for HALT and, when `SEQ_BRANCH_EN` is defined, for JUMP.
  - The register file writes at the edge that ends EXEC.
  - `instr_count` increments.
  - Next state and pc are chosen in this order:
    - op==`OP_HALT` → DONE, `halted`←1.
    - pc==`LAST_ADDR` → DONE.
    - Otherwise pc←pc+1 and next state is FETCH.
- **Boundaries:**
  - pc never wraps. `LAST_ADDR` terminates the sequence before any overflow.
  - HALT at `LAST_ADDR` sets `halted`=1.
- **Stop:**
  - In FETCH or DECODE, `stop` goes to DONE at the next edge with no write and no count increment.
  - In EXEC, the current instruction completes, including its write and count increment, then the block goes to DONE.
  - `stop` takes priority over `start` in the same cycle. In IDLE or DONE, `stop` is ignored.
- **Start while busy:** ignored.
- **Reset:** any state returns immediately to IDLE. Reset values: pc=0, ir=0, `rom_addr`=0, `op`/`wa`/`ra1`/`ra2`/`ext_data`=0, `rf_regwrite`=0, `busy`=0, `done`=0, `halted`=0, `instr_count`=0. Reset asserted during EXEC suppresses the write, because `rf_regwrite` drops asynchronously.

## Timing
- 3 cycles per instruction: FETCH, DECODE, EXEC.
- First FETCH occurs the cycle after `start` is sampled.
- `rf_regwrite` is a combinational function of state, ir and `cu_regwrite`. It is high for exactly one cycle per writing instruction.
- `done` rises the cycle after the final EXEC, or the cycle after `stop` is sampled in FETCH or DECODE.
- An N-instruction run without HALT takes 3N cycles from the first FETCH to `done`.
- All state and outputs other than `rf_regwrite` are registered.

## Configuration
- `SEQ_BRANCH_EN` defined: `OP_JUMP` in EXEC sets pc←ir[7:0], increments `instr_count`, forces `rf_regwrite`=0, and goes to FETCH. A JUMP at `LAST_ADDR` still jumps; the `LAST_ADDR` check is skipped for JUMP.
- `SEQ_BRANCH_EN` undefined: 4'hE is an ordinary opcode passed to `cu`, with normal write gating and pc+1.

## Test plan
- **Reset check:** assert `rst` mid-EXEC of a writing instruction → no register write; all outputs 0; state IDLE.
- **Three-instruction HALT run:** ROM[0..3] = load 5→R1, load 3→R2, add R1,R2→R3, HALT; `start` with `start_addr`=0 → three `rf_regwrite` pulses, R3=8, `done`=1 at cycle 12, `halted`=1, `instr_count`=4.
- **Start at LAST_ADDR:** `LAST_ADDR`=8'h03, ROM[3]=load 7→R4, `start_addr`=3 → one write, `done` after 3 cycles, `halted`=0, pc not wrapped.
- **Stop and ignored start:** assert `stop` during DECODE of the 2nd instruction → exactly 1 write, `instr_count`=1, `done` the next cycle. A `start` pulse while busy changes nothing.
- **Jump taken:** with `SEQ_BRANCH_EN`, ROM[0]=JUMP imm=8'h02, ROM[2]=HALT → `rf_regwrite` never asserted, `instr_count`=2, `halted`=1.
- **Jump as ordinary opcode:** without `SEQ_BRANCH_EN`, the same ROM → pc advances to 1 after ROM[0]. The write at ROM[0] follows `cu_regwrite`.
